// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM block.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Channel index width; a single channel still needs a 1-bit select port.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty, comparator against the shared counter, output flop.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             commit,
  input  logic             run,
  input  logic [WIDTH-1:0] cnt,
  output logic             pulse
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] pending, active, duty;
  logic             hit;

  // On a commit cycle the comparator already sees the value active is about to take.
  assign duty = commit ? pending : active;

  always_comb begin
    hit = 1'b0;
    if (duty == MAX)       hit = 1'b1;
    else if (duty != '0)   hit = (cnt < duty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      active  <= '0;
      pulse   <= 1'b0;
    end else begin
      if (wr)     pending <= wdata;
      if (commit) active  <= pending;
      pulse <= run & hit;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared edge/center-aligned counter driving CHANNELS comparators.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         center_mode,
  input  logic                         duty_valid,
  input  logic [ch_w(CHANNELS)-1:0]    duty_ch,
  input  logic [WIDTH-1:0]             duty_data,
  output logic                         duty_ready,
  output logic                         period_start,
  output logic [CHANNELS-1:0]          pulse
);

  localparam int               CW  = ch_w(CHANNELS);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt;
  logic             dir_up, en_q, rise, boundary, wr_ok;
  pwm_mode_e        mode_q, mode_eff;

  assign rise     = enable & ~en_q;
  assign mode_eff = rise ? pwm_mode_e'(center_mode) : mode_q;
  // cnt is parked at 0 while stopped, so the enable rise is itself a boundary.
  assign boundary = enable && (cnt == '0);
  assign wr_ok    = duty_valid && duty_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      dir_up       <= 1'b1;
      en_q         <= 1'b0;
      mode_q       <= PWM_EDGE;
      period_start <= 1'b0;
      duty_ready   <= 1'b0;
    end else begin
      en_q         <= enable;
      period_start <= boundary;
      duty_ready   <= 1'b1;
      if (rise) mode_q <= mode_eff;
      if (!enable) begin
        cnt    <= '0;
        dir_up <= 1'b1;
      end else if (mode_eff == PWM_EDGE) begin
        cnt <= cnt + ONE;
      end else if (dir_up) begin
        if (cnt == MAX) begin
          cnt    <= cnt - ONE;
          dir_up <= 1'b0;
        end else begin
          cnt <= cnt + ONE;
        end
      end else begin
        // Turn around on the way into 0 so the bottom is not repeated.
        cnt <= cnt - ONE;
        if (cnt == ONE) dir_up <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr     (wr_ok && (duty_ch == CW'(i))),
      .wdata  (duty_data),
      .commit (boundary),
      .run    (enable),
      .cnt    (cnt),
      .pulse  (pulse[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Randomized bench for pwm_multi against a period-position reference model.
module tb_pwm_multi;
  localparam int W   = 8;
  localparam int CH  = 3;
  localparam int MAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n, enable, center_mode, duty_valid;
  logic [1:0]    duty_ch;
  logic [W-1:0]  duty_data;
  logic          duty_ready, period_start;
  logic [CH-1:0] pulse;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .center_mode  (center_mode),
    .duty_valid   (duty_valid),
    .duty_ch      (duty_ch),
    .duty_data    (duty_data),
    .duty_ready   (duty_ready),
    .period_start (period_start),
    .pulse        (pulse)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  // reference model state: position in the run, buffered duties
  int pend[CH], act[CH], t;
  bit m_en, m_rdy, m_center;
  int hi[CH], ps_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cnt_at(input int tt);
    int p;
    if (!m_center) return tt % (MAX + 1);
    p = tt % (2 * MAX);
    return (p <= MAX) ? p : 2 * MAX - p;
  endfunction

  task automatic clr();
    for (int i = 0; i < CH; i++) hi[i] = 0;
    ps_cnt = 0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < CH; i++) begin pend[i] = 0; act[i] = 0; end
    t = 0; m_en = 0; m_rdy = 0; m_center = 0;
  endtask

  task automatic step();
    logic [CH-1:0] ep;
    logic          eps;
    int            c;
    ep = '0; eps = 1'b0;
    if (enable) begin
      if (!m_en) begin m_center = center_mode; t = 0; end
      c   = cnt_at(t);
      eps = (c == 0);
      if (eps) for (int i = 0; i < CH; i++) act[i] = pend[i];
      for (int i = 0; i < CH; i++)
        ep[i] = (act[i] == 0) ? 1'b0 : (act[i] == MAX) ? 1'b1 : (c < act[i]);
      t++;
    end
    if (duty_valid && m_rdy && duty_ch < CH) pend[duty_ch] = duty_data;
    m_en = enable;
    @(posedge clk); #1;
    m_rdy = 1;
    chk("pulse", pulse, ep);
    chk("pstart", period_start, eps);
    chk("ready", duty_ready, 1);
    for (int i = 0; i < CH; i++) hi[i] += pulse[i];
    ps_cnt += period_start;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr_step(input int ch, input int data);
    duty_valid = 1'b1; duty_ch = 2'(ch); duty_data = W'(data);
    step();
    duty_valid = 1'b0;
  endtask

  initial begin
    int k;
    bit seen;
    rst_n = 0; enable = 0; center_mode = 0; duty_valid = 0; duty_ch = 0; duty_data = 0;
    m_reset(); clr();
    #23;
    chk("rst_pulse", pulse, 0);
    chk("rst_pstart", period_start, 0);
    chk("rst_ready", duty_ready, 0);
    rst_n = 1; #1;
    chk("ready_after_release", duty_ready, 0);
    step();

    // edge mode, ch0 = 64
    wr_step(0, 64);
    enable = 1; clr();
    run(256);
    chk("edge64_high", hi[0], 64);
    chk("edge64_pstart", ps_cnt, 1);
    run(512);

    // constant-low / constant-high duties across three periods
    enable = 0; step();
    wr_step(1, 0); wr_step(2, MAX);
    enable = 1; clr();
    run(768);
    chk("duty00_high", hi[1], 0);
    chk("dutyff_high", hi[2], 768);
    chk("duty64_3per", hi[0], 192);
    chk("pstart_3per", ps_cnt, 3);

    // mid-period rewrite, then a write landing on the boundary cycle
    enable = 0; step();
    wr_step(1, 32);
    enable = 1; clr();
    run(100); wr_step(1, 200); run(155);
    chk("rewrite_cur", hi[1], 32);
    clr(); wr_step(1, 10); run(255);
    chk("rewrite_next", hi[1], 200);
    chk("rewrite_pstart", ps_cnt, 1);
    clr(); run(256);
    chk("bndwrite_delay", hi[1], 10);

    // mode changes while running are ignored
    center_mode = 1; clr(); run(256);
    chk("mode_ignored_ps", ps_cnt, 1);
    chk("mode_ignored_w", hi[1], 10);

    // center mode, duty 100
    enable = 0; step();
    wr_step(0, 100);
    enable = 1; clr(); run(510);
    chk("center_high", hi[0], 199);
    chk("center_pstart", ps_cnt, 1);
    clr(); run(510);
    chk("center_high2", hi[0], 199);
    chk("center_pstart2", ps_cnt, 1);

    // randomized traffic with enable/mode churn
    center_mode = 0;
    for (int n = 0; n < 3000; n++) begin
      duty_valid = ($urandom_range(0, 3) == 0);
      duty_ch    = 2'($urandom_range(0, 3));
      k          = $urandom_range(0, 9);
      duty_data  = (k == 0) ? W'(0) : (k == 1) ? W'(MAX) : W'($urandom);
      if ($urandom_range(0, 15) == 0) center_mode = ~center_mode;
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      step();
    end
    duty_valid = 0;

    // asynchronous reset while a pulse is high
    enable = 0; center_mode = 0; step();
    wr_step(0, 128);
    enable = 1;
    seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      step();
      seen = pulse[0];
    end
    chk("pulse_seen_before_rst", seen, 1);
    #3 rst_n = 0; enable = 0; #1;
    m_reset();
    chk("async_rst_pulse", pulse, 0);
    chk("async_rst_pstart", period_start, 0);
    chk("async_rst_ready", duty_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("in_rst_ready", duty_ready, 0);
    #2 rst_n = 1; #1;
    chk("post_rst_ready", duty_ready, 0);
    step();
    enable = 1; clr(); run(300);
    chk("post_rst_duties0", hi[0] + hi[1] + hi[2], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
